// File: rtl/sdr_linear_checker.sv
// -----------------------------------------------------------------------------
// sdr_linear_checker
//
// Watches the sampled SDR output of a device that is expected to count up
// by one per valid sample. It searches for LOCK_CNT consecutive +1 steps,
// then checks NUM_SAMPLES further samples against the predicted ramp and
// reports matches, mismatches and the most recent bad sample.
//
// Ports
//   clkin      : single clock, rising edge
//   reset      : asynchronous active-low reset, released synchronously
//   en         : run request (level); dropping it returns to IDLE
//   q_valid    : q carries a sample this cycle
//   q          : sampled SDR output, WIDTH bits
//   locked     : checker is in LOCKED
//   done       : run completed (DONE or FAIL)
//   error      : sticky failure flag (mismatch or search timeout)
//   err_cnt    : mismatches seen in LOCKED (saturating)
//   match_cnt  : matches seen in LOCKED (saturating)
//   last_bad   : most recent mismatching sample
//
// Timing: q/q_valid are registered on the edge where they are presented and
// acted upon at the following edge, so a sample at edge k shows up in the
// counters and flags after edge k+1.
// -----------------------------------------------------------------------------
module sdr_linear_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int NUM_SAMPLES = 256,
  parameter int SEARCH_TO   = 64
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q,
  output logic             locked,
  output logic             done,
  output logic             error,
  output logic [15:0]      err_cnt,
  output logic [15:0]      match_cnt,
  output logic [WIDTH-1:0] last_bad
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int TO_W  = $clog2(SEARCH_TO + 1);
  localparam int TOT_W = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    LOCKED = 3'd2,
    DONE   = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Reset conditioning: assertion reaches every flop immediately, release is
  // retimed through two flops so no flop sees it close to a clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // Input stage. A sample presented together with en=0 is dropped here, which
  // gives the en=0 exit priority over a coincident sample.
  // ---------------------------------------------------------------------------
  logic             smp_valid;
  logic [WIDTH-1:0] smp_q;

  // NOTE: every flop here is plain control/datapath state (no memory array),
  // so all of it can and does take the asynchronous reset.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      smp_valid <= 1'b0;
      smp_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state so every
      // flop samples the pre-edge values of its neighbours.
      smp_valid <= q_valid & en;
      if (q_valid) begin
        smp_q <= q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q;     // predicted value of the next sample
  logic             have_exp;  // exp_q is meaningful (first SEARCH sample seen)
  logic [RUN_W-1:0] run;       // consecutive +1 steps seen in SEARCH
  logic [TO_W-1:0]  scnt;      // valid samples consumed in SEARCH
  logic [TOT_W-1:0] tot;       // samples consumed in LOCKED

  logic start;     // IDLE with en=1: begin a fresh run
  logic take;      // a registered sample is consumed this edge
  logic step_ok;   // sample continues the ramp
  logic lock_hit;  // this sample completes the lock run
  logic to_hit;    // this sample exhausts the search budget
  logic done_hit;  // this sample is the last one to check

  assign start    = (state == IDLE) && en;
  assign take     = smp_valid && en;
  assign step_ok  = (smp_q == exp_q);
  assign lock_hit = have_exp && step_ok && (run == RUN_W'(LOCK_CNT - 1));
  assign to_hit   = (scnt == TO_W'(SEARCH_TO - 1));
  assign done_hit = (tot == TOT_W'(NUM_SAMPLES - 1));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      have_exp  <= 1'b0;
      run       <= '0;
      scnt      <= '0;
      tot       <= '0;
      error     <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
      last_bad  <= '0;
    end else if (start) begin
      exp_q     <= '0;
      have_exp  <= 1'b0;
      run       <= '0;
      scnt      <= '0;
      tot       <= '0;
      error     <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
      last_bad  <= '0;
    end else if (take) begin
      case (state)
        SEARCH: begin
          // Resync the prediction on every search sample.
          exp_q    <= smp_q + WIDTH'(1);
          have_exp <= 1'b1;
          scnt     <= scnt + TO_W'(1);
          if (have_exp && step_ok) begin
            run <= run + RUN_W'(1);
          end else begin
            run <= '0;
          end
          if (to_hit && !lock_hit) begin
            error <= 1'b1;
          end
        end
        LOCKED: begin
          // Free-running prediction: no resync after a mismatch, and the
          // natural modulo-2^WIDTH add makes all-ones -> 0 a match.
          exp_q <= exp_q + WIDTH'(1);
          tot   <= tot + TOT_W'(1);
          if (step_ok) begin
            if (match_cnt != 16'hFFFF) begin
              match_cnt <= match_cnt + 16'd1;
            end
          end else begin
            if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
            error    <= 1'b1;
            last_bad <= smp_q;
          end
        end
        default: ;  // IDLE, DONE, FAIL: results frozen
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_nxt unassigned, which would infer a latch.
    state_nxt = state;
    if (state == IDLE) begin
      if (en) begin
        state_nxt = SEARCH;
      end
    end else if (!en) begin
      state_nxt = IDLE;
    end else if (take) begin
      case (state)
        SEARCH: begin
          if (lock_hit) begin
            state_nxt = LOCKED;
          end else if (to_hit) begin
            state_nxt = FAIL;
          end
        end
        LOCKED: begin
          if (done_hit) begin
            state_nxt = DONE;
          end
        end
        default: ;  // DONE and FAIL hold while en=1
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    locked = (state == LOCKED);
    done   = (state == DONE) || (state == FAIL);
  end

endmodule

// File: tb/tb_sdr_linear_checker.sv
// -----------------------------------------------------------------------------
// tb_sdr_linear_checker
//
// Directed bench for sdr_linear_checker with default parameters. Inputs are
// driven 1 time unit after the rising edge; outputs are read at the same
// point, so a sample presented at edge k is visible after edge k+1.
// -----------------------------------------------------------------------------
module tb_sdr_linear_checker;

  localparam int WIDTH = 8;

  logic             clkin;
  logic             reset;
  logic             en;
  logic             q_valid;
  logic [WIDTH-1:0] q;
  logic             locked;
  logic             done;
  logic             error;
  logic [15:0]      err_cnt;
  logic [15:0]      match_cnt;
  logic [WIDTH-1:0] last_bad;

  int checks;
  int errors;
  bit locked_seen;

  sdr_linear_checker #(
    .WIDTH      (WIDTH),
    .LOCK_CNT   (4),
    .NUM_SAMPLES(256),
    .SEARCH_TO  (64)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .en       (en),
    .q_valid  (q_valid),
    .q        (q),
    .locked   (locked),
    .done     (done),
    .error    (error),
    .err_cnt  (err_cnt),
    .match_cnt(match_cnt),
    .last_bad (last_bad)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(negedge clkin) begin
    if (locked) locked_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    q       = v;
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
  endtask

  // Drop en for two cycles, then raise it for the start cycle.
  task automatic restart();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    en      = 1'b0;
    q_valid = 1'b0;
    q       = '0;
    locked_seen = 1'b0;

    tick();
    tick();
    check("reset_flags", {29'd0, locked, done, error}, 32'd0);
    check("reset_cnts", {err_cnt, match_cnt}, 32'd0);
    check("reset_last_bad", {24'd0, last_bad}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();

    // ---- Clean ramp 0x10.., crossing 0xFF->0x00 while locked -------------
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    check("ramp_lock_latency", {31'd0, locked}, 32'd0);
    tick();
    check("ramp_locked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 256; i++) send(8'h15 + 8'(i));
    check("ramp_not_done_yet", {31'd0, done}, 32'd0);
    tick();
    check("ramp_done", {30'd0, locked, done}, 32'd1);
    check("ramp_match", {16'd0, match_cnt}, 32'd256);
    check("ramp_err", {16'd0, err_cnt}, 32'd0);
    check("ramp_error", {31'd0, error}, 32'd0);

    // ---- en=0 exit holds results; next start clears them -----------------
    en = 1'b0;
    tick();
    tick();
    check("exit_flags", {30'd0, locked, done}, 32'd0);
    check("exit_match_held", {16'd0, match_cnt}, 32'd256);
    en = 1'b1;
    tick();
    check("start_clears", {err_cnt, match_cnt}, 32'd0);

    // ---- Single glitch: 0x55 replaces 0x40 ---------------------------------
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    for (int v = 8'h35; v <= 8'h4F; v++) send((v == 8'h40) ? 8'h55 : 8'(v));
    tick();
    check("glitch_err", {16'd0, err_cnt}, 32'd1);
    check("glitch_match", {16'd0, match_cnt}, 32'd26);
    check("glitch_last_bad", {24'd0, last_bad}, 32'h55);
    check("glitch_error", {31'd0, error}, 32'd1);
    check("glitch_still_locked", {31'd0, locked}, 32'd1);

    // ---- Search timeout with constant 0xA5 ---------------------------------
    restart();
    locked_seen = 1'b0;
    for (int i = 0; i < 63; i++) send(8'hA5);
    tick();
    check("to_not_yet", {30'd0, done, error}, 32'd0);
    send(8'hA5);
    tick();
    check("to_fail", {30'd0, done, error}, 32'd3);
    check("to_never_locked", {31'd0, locked_seen}, 32'd0);
    tick();
    tick();
    tick();
    check("to_hold", {30'd0, done, error}, 32'd3);

    // ---- Gapped ramp -------------------------------------------------------
    restart();
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i));
      tick();
    end
    send(8'h14);
    check("gap_not_locked", {31'd0, locked}, 32'd0);
    tick();
    check("gap_locked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("gap_idle_hold", {match_cnt, 15'd0, locked}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      send(8'h15 + 8'(i));
      tick();
    end
    check("gap_done", {30'd0, locked, done}, 32'd1);
    check("gap_match", {16'd0, match_cnt}, 32'd256);
    check("gap_err", {15'd0, error, err_cnt}, 32'd0);

    // ---- Reset mid-run, then relock ---------------------------------------
    restart();
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
    for (int i = 0; i < 20; i++) send(8'h65 + 8'(i));
    tick();
    check("mid_locked", {31'd0, locked}, 32'd1);
    check("mid_match", {16'd0, match_cnt}, 32'd20);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_flags", {29'd0, locked, done, error}, 32'd0);
    check("rst_async_cnts", {err_cnt, match_cnt}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) send(8'(i));
    tick();
    check("relock", {31'd0, locked}, 32'd1);
    for (int i = 5; i < 8; i++) send(8'(i));
    tick();
    check("relock_match", {16'd0, match_cnt}, 32'd3);
    check("relock_err", {15'd0, error, err_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
